// File: rtl/hpc2_and_arbiter.sv
// Round-robin front end sharing one masked HPC2 AND gadget between several requesters.
// Schedules the gadget's inb/rnd (issue cycle) and ina (next cycle) and routes results back.
module hpc2_and_arbiter #(
  parameter int unsigned d    = 2,
  parameter int unsigned NREQ = 2,
  localparam int unsigned NRND = d * (d - 1) / 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*d-1:0]   req_ina,
  input  logic [NREQ*d-1:0]   req_inb,
  output logic [NREQ-1:0]     req_ready,
  input  logic                rnd_valid,
  input  logic [NRND-1:0]     rnd,
  output logic                rnd_ready,
  output logic [d-1:0]        g_ina,
  output logic [d-1:0]        g_inb,
  output logic [NRND-1:0]     g_rnd,
  input  logic [d-1:0]        g_out,
  output logic [NREQ-1:0]     res_valid,
  output logic [d-1:0]        res_data
);

  localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IdW-1:0] LastId = IdW'(NREQ - 1);

  logic [IdW-1:0] last_grant_q;
  logic [IdW-1:0] gnt_id;
  logic           found;
  logic           issue;
  logic [d-1:0]   ina_d, ina_q;
  logic           v1_q, v2_q;
  logic [IdW-1:0] id1_q, id2_q;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_id = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      logic [IdW-1:0] idx;
      idx = IdW'((int'(last_grant_q) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  // Randomness only reaches the gadget in a cycle where it is also consumed.
  always_comb begin
    issue     = (|req_valid) & rnd_valid & ~flush;
    req_ready = '0;
    rnd_ready = issue;
    g_inb     = '0;
    g_rnd     = '0;
    ina_d     = '0;
    if (issue) begin
      req_ready[gnt_id] = 1'b1;
      g_inb             = req_inb[gnt_id*d +: d];
      g_rnd             = rnd;
      ina_d             = req_ina[gnt_id*d +: d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ina_q        <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      id1_q        <= '0;
      id2_q        <= '0;
      last_grant_q <= LastId;
    end else if (flush) begin
      ina_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      ina_q <= ina_d;
      v1_q  <= issue;
      id1_q <= gnt_id;
      v2_q  <= v1_q;
      id2_q <= id1_q;
      if (issue) last_grant_q <= gnt_id;
    end
  end

  always_comb begin
    res_valid = '0;
    if (v2_q && !flush) res_valid[id2_q] = 1'b1;
  end

  assign g_ina    = ina_q;
  assign res_data = g_out;

endmodule

// File: tb/tb_hpc2_and_arbiter.sv
// Randomized bench for hpc2_and_arbiter with a behavioural gadget and a result scoreboard.
module tb_hpc2_and_arbiter;

  localparam int unsigned D    = 2;
  localparam int unsigned NREQ = 2;
  localparam int unsigned NRND = D * (D - 1) / 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*D-1:0] req_ina = '0;
  logic [NREQ*D-1:0] req_inb = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rnd_valid = 1'b0;
  logic [NRND-1:0]   rnd = '0;
  logic              rnd_ready;
  logic [D-1:0]      g_ina, g_inb, g_out, res_data;
  logic [NRND-1:0]   g_rnd;
  logic [NREQ-1:0]   res_valid;

  always #5 clk = ~clk;

  hpc2_and_arbiter #(.d(D), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ina   (req_ina),
    .req_inb   (req_inb),
    .req_ready (req_ready),
    .rnd_valid (rnd_valid),
    .rnd       (rnd),
    .rnd_ready (rnd_ready),
    .g_ina     (g_ina),
    .g_inb     (g_inb),
    .g_rnd     (g_rnd),
    .g_out     (g_out),
    .res_valid (res_valid),
    .res_data  (res_data)
  );

  // Behavioural two-share gadget: inb/rnd at t, ina at t+1, product shares at t+2.
  logic [D-1:0]    gb_q = '0;
  logic [NRND-1:0] gr_q = '0;
  logic [D-1:0]    gout_q = '0;

  function automatic logic [D-1:0] gad(input logic [D-1:0] a, input logic [D-1:0] b,
                                       input logic [NRND-1:0] r);
    logic [D-1:0] o;
    o = '0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) o[i] = o[i] ^ (a[i] & b[j]);
    o[0] = o[0] ^ r[0];
    o[1] = o[1] ^ r[0];
    return o;
  endfunction

  always @(posedge clk) begin
    gb_q   <= g_inb;
    gr_q   <= g_rnd;
    gout_q <= gad(g_ina, gb_q, gr_q);
  end
  assign g_out = gout_q;

  typedef struct {int id; bit val; int due;} exp_t;
  exp_t         q[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           ptr = NREQ - 1;
  logic [D-1:0] exp_gina = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Result monitor: every cycle either the head entry is due or nothing may appear.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("res_valid", 64'(res_valid), 64'd1 << q[0].id);
        if (res_valid == NREQ'(1 << q[0].id)) chk("res_xor", 64'(^res_data), 64'(q[0].val));
        void'(q.pop_front());
      end else begin
        chk("res_idle", 64'(res_valid), 64'd0);
      end
    end
  end

  task automatic step(input logic [NREQ-1:0] rv, input bit rdv, input bit fl);
    int           gnt;
    bit           issue;
    logic [D-1:0] a, b;
    exp_t         e;
    @(posedge clk);
    #1;
    req_valid = rv;
    rnd_valid = rdv;
    flush     = fl;
    req_ina   = (NREQ*D)'($urandom);
    req_inb   = (NREQ*D)'($urandom);
    rnd       = NRND'($urandom);
    // Operations issued one or two cycles ago die on a flush.
    if (fl) while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
    issue = (rv != 0) && rdv && !fl;
    gnt = -1;
    a = '0;
    b = '0;
    if (issue) begin
      for (int i = 1; i <= NREQ; i++) begin
        int k;
        k = (ptr + i) % NREQ;
        if (gnt < 0 && rv[k]) gnt = k;
      end
      a = req_ina[gnt*D +: D];
      b = req_inb[gnt*D +: D];
    end
    @(negedge clk);
    chk("req_ready", 64'(req_ready), issue ? (64'd1 << gnt) : 64'd0);
    chk("rnd_ready", 64'(rnd_ready), 64'(issue));
    chk("g_inb", 64'(g_inb), 64'(b));
    chk("g_rnd", 64'(g_rnd), issue ? 64'(rnd) : 64'd0);
    chk("g_ina", 64'(g_ina), 64'(exp_gina));
    exp_gina = a;
    if (issue) begin
      ptr   = gnt;
      e.id  = gnt;
      e.val = (^a) & (^b);
      e.due = cyc + 2;
      q.push_back(e);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    req_valid = '0;
    rnd_valid = 1'b0;
    flush     = 1'b0;
    q.delete();
    ptr      = NREQ - 1;
    exp_gina = '0;
    #1;
    chk("rst_g_ina", 64'(g_ina), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rnd_ready", 64'(rnd_ready), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("reset_outputs", 64'({req_ready, rnd_ready, g_ina, g_inb, g_rnd, res_valid}), 64'd0);
    #20;
    rst_n = 1'b1;
    #1;
    chk("post_reset_outputs", 64'({req_ready, rnd_ready, g_ina, g_inb, g_rnd, res_valid}), 64'd0);

    // Both requesters busy: strict alternation starting at requester 0.
    for (int i = 0; i < 6; i++) step(2'b11, 1'b1, 1'b0);
    // Randomness starved: stall with pointer held.
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    // Issue then flush, then a fresh issue.
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b1);
    step(2'b01, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    // Single requester wins every cycle regardless of pointer.
    for (int i = 0; i < 4; i++) step(2'b10, 1'b1, 1'b0);
    // Reset between issue and result.
    step(2'b10, 1'b1, 1'b0);
    async_reset();
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      step(NREQ'($urandom), ($urandom % 5) != 0, ($urandom % 10) == 0);
    end
    for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 1'b0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
